// File: rtl/cmos_rgb565_axis.sv
`timescale 1ns/1ps
// cmos_rgb565_axis
//   Captures a DVP-style camera byte stream (two bytes per RGB565 pixel),
//   expands each pixel to RGB888 and presents it on an AXI4-Stream video
//   master with start-of-frame (tuser) and end-of-line (tlast) flags.
//   The camera cannot be stalled, so a small FIFO absorbs back-pressure;
//   if it overflows, the rest of the frame is dropped.
//
// Ports
//   cmos_pclk      camera pixel clock, the only clock
//   rst_n          asynchronous active-low reset
//   cmos_href      line valid
//   cmos_vsync     frame sync (VSYNC_POL = level during vertical blanking)
//   cmos_data      camera byte
//   m_axis_*       AXI4-Stream master, tdata = {R, G, B}
//   line_pixels    pixels pushed on the last completed captured line
//   frame_cnt      frame edges seen while running or dropping
//   overflow       sticky flag, set when a pixel is dropped
//   ovf_clr        clears overflow (a set in the same cycle wins)
//
// state | meaning
// SYNC  | waiting for the first frame edge after reset
// SKIP  | discarding settling frames
// RUN   | capturing pixels
// DROP  | FIFO overflowed, discard until the next frame edge
module cmos_rgb565_axis #(
  parameter bit VSYNC_POL   = 1'b1,
  parameter int SKIP_FRAMES = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int LINE_W      = 12
) (
  input  logic              cmos_pclk,
  input  logic              rst_n,
  input  logic              cmos_href,
  input  logic              cmos_vsync,
  input  logic [7:0]        cmos_data,
  output logic [23:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic [LINE_W-1:0] line_pixels,
  output logic [15:0]       frame_cnt,
  output logic              overflow,
  input  logic              ovf_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] SKIP_N = 4'(SKIP_FRAMES);
  localparam logic [AW:0] DEPTH_N = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_SYNC, ST_SKIP, ST_RUN, ST_DROP} state_t;

  // Input pipeline. vsync registers reset to the blanking level so a pin
  // already in blanking at release does not look like a frame edge.
  logic       href_r, href_d, vsync_r, vsync_d;
  logic [7:0] data_r;

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      href_r  <= 1'b0;
      href_d  <= 1'b0;
      vsync_r <= VSYNC_POL;
      vsync_d <= VSYNC_POL;
      data_r  <= '0;
    end else begin
      href_r  <= cmos_href;
      href_d  <= href_r;
      vsync_r <= cmos_vsync;
      vsync_d <= vsync_r;
      data_r  <= cmos_data;
    end
  end

  logic frame_edge, href_fall;
  assign frame_edge = (vsync_r == VSYNC_POL) && (vsync_d != VSYNC_POL);
  assign href_fall  = href_d && !href_r;

  // Byte assembly. A byte arriving on a frame edge starts a fresh pixel.
  logic        phase;
  logic [7:0]  byte0;
  logic        pix_done;
  logic [4:0]  r5, b5;
  logic [5:0]  g6;
  logic [23:0] rgb_new;

  assign pix_done = href_r && phase && !frame_edge;
  assign r5       = byte0[7:3];
  assign g6       = {byte0[2:0], data_r[7:5]};
  assign b5       = data_r[4:0];
  assign rgb_new  = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      byte0 <= '0;
    end else begin
      if (!href_r)         phase <= 1'b0;
      else if (frame_edge) phase <= 1'b1;
      else                 phase <= !phase;
      if (href_r && (frame_edge || !phase)) byte0 <= data_r;
    end
  end

  // FIFO occupancy is needed by the control path to detect overflow.
  logic [AW:0]   cnt, cnt_n;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic          full, pop;
  assign full = (cnt == DEPTH_N);
  assign pop  = m_axis_tvalid && m_axis_tready;

  // Control
  state_t      state, state_n;
  logic [3:0]  skip_cnt, skip_n;
  logic        sof_pend, sof_n;
  logic        hold_v, hold_v_n, hold_load;
  logic [23:0] hold_rgb;
  logic        push_req, push_last, push_ok, push_drop;
  logic        enter_run, frame_inc;
  logic [25:0] push_word;

  always_comb begin
    state_n   = state;
    skip_n    = skip_cnt;
    sof_n     = sof_pend;
    hold_v_n  = hold_v;
    hold_load = 1'b0;
    push_req  = 1'b0;
    push_last = 1'b0;
    enter_run = 1'b0;
    frame_inc = 1'b0;
    unique case (state)
      ST_SYNC: if (frame_edge) begin
        if (SKIP_FRAMES == 0) begin
          state_n   = ST_RUN;
          enter_run = 1'b1;
        end else begin
          state_n = ST_SKIP;
          skip_n  = '0;
        end
      end
      ST_SKIP: if (frame_edge) begin
        skip_n = skip_cnt + 4'd1;
        if (skip_n == SKIP_N) begin
          state_n   = ST_RUN;
          enter_run = 1'b1;
        end
      end
      ST_RUN: begin
        // End of line or frame flushes the held pixel as the line's last.
        if (frame_edge || href_fall) begin
          push_req  = hold_v;
          push_last = 1'b1;
          hold_v_n  = 1'b0;
        end else if (pix_done) begin
          push_req  = hold_v;
          hold_load = 1'b1;
          hold_v_n  = 1'b1;
        end
        if (frame_edge) begin
          frame_inc = 1'b1;
          enter_run = 1'b1;
        end
      end
      ST_DROP: if (frame_edge) begin
        state_n   = ST_RUN;
        frame_inc = 1'b1;
        enter_run = 1'b1;
      end
      default: state_n = ST_SYNC;
    endcase
    push_ok   = push_req && !full;
    push_drop = push_req && full;
    if (push_drop) begin
      hold_v_n  = 1'b0;
      hold_load = 1'b0;
      if (!frame_edge) state_n = ST_DROP;
    end
    if (push_ok)   sof_n = 1'b0;
    if (enter_run) sof_n = 1'b1;
  end

  assign push_word = {sof_pend, push_last, hold_rgb};

  logic [LINE_W-1:0] line_cnt;

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SYNC;
      skip_cnt    <= '0;
      sof_pend    <= 1'b0;
      hold_v      <= 1'b0;
      hold_rgb    <= '0;
      overflow    <= 1'b0;
      frame_cnt   <= '0;
      line_cnt    <= '0;
      line_pixels <= '0;
    end else begin
      state    <= state_n;
      skip_cnt <= skip_n;
      sof_pend <= sof_n;
      hold_v   <= hold_v_n;
      if (hold_load) hold_rgb <= rgb_new;
      if (push_drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
      if (state == ST_RUN && href_fall)
        line_pixels <= (push_ok && line_cnt != '1) ? line_cnt + LINE_W'(1) : line_cnt;
      if (frame_edge || href_fall)       line_cnt <= '0;
      else if (push_ok && line_cnt != '1) line_cnt <= line_cnt + LINE_W'(1);
    end
  end

  // FIFO with a registered head. The head stays counted until it is
  // accepted, so the FIFO_DEPTH entries include the one on the bus.
  logic [25:0] mem [FIFO_DEPTH];

  assign cnt_n    = cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
  assign rd_ptr_n = rd_ptr + AW'(pop);

  always_ff @(posedge cmos_pclk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      cnt           <= cnt_n;
      rd_ptr        <= rd_ptr_n;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      m_axis_tvalid <= (cnt_n != '0);
      if (cnt_n != '0) begin
        // Pushing into an otherwise empty FIFO: forward the new word.
        if (push_ok && cnt == (AW+1)'(pop))
          {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= push_word;
        else
          {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= mem[rd_ptr_n];
      end
    end
  end

endmodule
